// File: rtl/divider_if.sv
// ---------------------------------------------------------------------------
// divider_if
//   Bundles the request/result signals of the sequential divider.
//
//   Handshake (start / busy / data_valid):
//     - A request is accepted on a rising clk edge where start==1, busy==0 and
//       rst==0. in_0 / in_1 are captured on that same edge and may change
//       freely afterwards.
//     - start while busy==1 is ignored. Nothing is queued.
//     - data_valid is a one-cycle pulse. quotient, remainder and div_by_zero
//       are valid in that cycle and hold until the next result loads.
//       There is no backpressure on the result.
//
//   Signals:
//     start        master -> slave   request
//     in_0         master -> slave   dividend
//     in_1         master -> slave   divisor
//     quotient     slave  -> master  floor(in_0 / in_1)
//     remainder    slave  -> master  in_0 mod in_1
//     div_by_zero  slave  -> master  the captured divisor was zero
//     busy         slave  -> master  an operation is in flight
//     data_valid   slave  -> master  result pulse
//     state_dbg    slave  -> master  current FSM state, for observation only
// ---------------------------------------------------------------------------
interface divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] in_0;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;
    logic             data_valid;
    logic [1:0]       state_dbg;

    modport master (
        output start,
        output in_0,
        output in_1,
        input  quotient,
        input  remainder,
        input  div_by_zero,
        input  busy,
        input  data_valid,
        input  state_dbg
    );

    modport slave (
        input  start,
        input  in_0,
        input  in_1,
        output quotient,
        output remainder,
        output div_by_zero,
        output busy,
        output data_valid,
        output state_dbg
    );
endinterface

// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider
//   Sequential restoring divider for unsigned operands. It produces one
//   quotient bit per clock by shift-subtract. It uses the same start /
//   data_valid handshake as the shift-add multiplier, so the two can be used
//   together.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset. It aborts any operation in flight.
//     bus   divider_if.slave
//             start, in_0 (dividend), in_1 (divisor)
//             quotient, remainder, div_by_zero, busy, data_valid, state_dbg
//
//   Timing:
//     - A request is accepted at edge N.
//     - The edges N+1 .. N+WIDTH perform the WIDTH iterations.
//     - The last iteration loads the result and raises data_valid.
//     - The DONE cycle drops data_valid and busy.
//     - The earliest next accept is therefore the first IDLE edge after DONE.
//
//   Divisor 0:
//     The loop runs unchanged. Every trial subtract succeeds, which gives
//     quotient = all ones and remainder = dividend. div_by_zero flags this
//     result.
// ---------------------------------------------------------------------------
module divider #(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    divider_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q, d_d;        // captured divisor
    logic [WIDTH:0]   r_q, r_d;        // partial remainder with one guard bit
    logic [CW-1:0]    cnt_q, cnt_d;    // iterations done so far
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             dv_q, dv_d;

    // One iteration of the restoring step.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_sub;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             fits;

    // The guard bit of R is always 0 after a step, because R < D. Only the
    // shifted value R' needs the guard bit.
    logic             unused_r_guard;
    assign unused_r_guard = r_q[WIDTH];

    always_comb begin
        r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        fits    = (r_shift >= {1'b0, d_q});
        r_sub   = r_shift - {1'b0, d_q};
        r_next  = fits ? r_sub : r_shift;
        q_next  = {q_q[WIDTH-2:0], fits};
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        busy_d  = busy_q;
        dv_d    = dv_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    q_d     = bus.in_0;
                    d_d     = bus.in_1;
                    r_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                q_d   = q_next;
                r_d   = r_next;
                cnt_d = cnt_q + 1'b1;
                // The last iteration loads the result on the same edge.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quot_d  = q_next;
                    rem_d   = r_next[WIDTH-1:0];
                    dbz_d   = (d_q == '0);
                    dv_d    = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                dv_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            dv_q    <= dv_d;
        end
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = busy_q;
    assign bus.data_valid  = dv_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_divider.sv
// ---------------------------------------------------------------------------
// tb_divider
//   Directed test of the sequential divider.
//   Expected results are packed as {dbz[7:0], quotient[7:0], remainder[7:0]}.
//   They are queued at the accepting edge together with the cycle number of
//   that edge. A monitor pops them when data_valid shows up.
// ---------------------------------------------------------------------------
module tb_divider;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    divider_if #(.WIDTH(W)) bus();

    divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];
    int          acc_q[$];
    logic [23:0] mon_e;
    int          mon_acc;
    logic        prev_dv = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] pk(input logic z, input logic [7:0] q, input logic [7:0] r);
        return {7'd0, z, q, r};
    endfunction

    function automatic logic [23:0] model(input logic [7:0] a, input logic [7:0] b);
        if (b == 8'd0) return pk(1'b1, 8'hff, a);
        return pk(1'b0, 8'(a / b), 8'(a % b));
    endfunction

    // Result monitor, sampled 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (prev_dv) begin
            check("dv_pulse_len", 32'(bus.data_valid), 0);
            check("busy_drop", 32'(bus.busy), 0);
        end
        if (bus.data_valid) begin
            check("busy_with_dv", 32'(bus.busy), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_dv", 32'(bus.data_valid), 0);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_acc = acc_q.pop_front();
                check("latency", cyc - mon_acc, W);
                check("quotient", 32'(bus.quotient), 32'(mon_e[15:8]));
                check("remainder", 32'(bus.remainder), 32'(mon_e[7:0]));
                check("div_by_zero", 32'(bus.div_by_zero), 32'(mon_e[16]));
            end
        end
        prev_dv = bus.data_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [23:0] e);
        int k = 0;
        while (bus.busy && k < 50) begin
            step();
            k++;
        end
        check("issue_idle", 32'(bus.busy), 0);
        bus.start = 1'b1;
        bus.in_0  = a;
        bus.in_1  = b;
        step();
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        check("accept_busy", 32'(bus.busy), 1);
        bus.start = 1'b0;
        bus.in_0  = 8'($urandom_range(0, 255));
        bus.in_1  = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || bus.busy) && k < 60) begin
            step();
            k++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_quotient"}, 32'(bus.quotient), 0);
        check({tag, "_remainder"}, 32'(bus.remainder), 0);
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_dv"}, 32'(bus.data_valid), 0);
        check({tag, "_state"}, 32'(bus.state_dbg), 0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] va[8] = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd200, 8'd254, 8'd255};
    logic [7:0] vb[8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd127, 8'd128, 8'd254, 8'd255};

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.in_0  = '0;
        bus.in_1  = '0;
        repeat (3) step();
        check_zero_outputs("reset");
        rst = 1'b0;
        step();

        // Basic division, then the result must hold.
        issue(8'd200, 8'd7, pk(1'b0, 8'd28, 8'd4));
        wait_idle();
        repeat (3) step();
        check("hold_quotient", 32'(bus.quotient), 28);
        check("hold_remainder", 32'(bus.remainder), 4);

        // Dividend < divisor, and divisor 1.
        issue(8'd5, 8'd9, pk(1'b0, 8'd0, 8'd5));
        wait_idle();
        issue(8'd255, 8'd1, pk(1'b0, 8'd255, 8'd0));
        wait_idle();

        // Divide by zero; the flag holds, then clears on the next result.
        issue(8'd77, 8'd0, pk(1'b1, 8'd255, 8'd77));
        wait_idle();
        step();
        check("dbz_held", 32'(bus.div_by_zero), 1);
        issue(8'd10, 8'd3, pk(1'b0, 8'd3, 8'd1));
        wait_idle();
        check("dbz_cleared", 32'(bus.div_by_zero), 0);

        // Start pulses during a run are ignored.
        issue(8'd200, 8'd7, pk(1'b0, 8'd28, 8'd4));
        for (int i = 0; i < 4; i++) begin
            bus.start = 1'b1;
            bus.in_0  = 8'd99;
            bus.in_1  = 8'd2;
            step();
            bus.start = 1'b0;
            step();
        end
        wait_idle();
        repeat (4) step();
        check("no_extra_accept", 32'(bus.busy), 0);

        // Start held high with operands changing every cycle.
        bus.start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.in_0 = 8'($urandom_range(0, 255));
            bus.in_1 = 8'($urandom_range(0, 15));
            if (!bus.busy) begin
                exp_q.push_back(model(bus.in_0, bus.in_1));
                acc_q.push_back(cyc + 1);
            end
            step();
        end
        bus.start = 1'b0;
        wait_idle();

        // Reset in the middle of an operation aborts it.
        issue(8'd100, 8'd3, pk(1'b0, 8'd33, 8'd1));
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        check_zero_outputs("abort");
        repeat (12) step();
        check("abort_idle_busy", 32'(bus.busy), 0);
        check("abort_idle_dv", 32'(bus.data_valid), 0);
        issue(8'd100, 8'd3, pk(1'b0, 8'd33, 8'd1));
        wait_idle();

        // Reset in the same cycle as start: nothing is accepted.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.in_0  = 8'd50;
        bus.in_1  = 8'd5;
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", 32'(bus.busy), 0);
        repeat (10) step();
        check("rst_start_idle", 32'(bus.busy), 0);

        // Boundary operand grid, checked against the / and % reference.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                issue(va[i], vb[j], model(va[i], vb[j]));
            end
        end
        wait_idle();

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
